// File: rtl/song_player.sv
// song_player: Ode-to-Joy autoplay sequencer with start/pause/restart; define SONG_PLAYER_GAP_EN to silence the last tick of notes lasting 2+ beats
module song_player #(
  parameter int SONG_LEN = 16,
  parameter int LOOP     = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BEAT,
  input  logic       START,
  input  logic       PAUSE,
  output logic [3:0] note,
  output logic [7:0] Led,
  output logic       busy,
  output logic       done
);
  localparam int AW = SONG_LEN > 1 ? $clog2(SONG_LEN) : 1;
  localparam logic [6:0] SONG [16] = '{
    {4'd3, 3'd2}, {4'd3, 3'd2}, {4'd4, 3'd2}, {4'd5, 3'd2},
    {4'd5, 3'd2}, {4'd4, 3'd2}, {4'd3, 3'd2}, {4'd2, 3'd2},
    {4'd1, 3'd2}, {4'd1, 3'd2}, {4'd2, 3'd2}, {4'd3, 3'd2},
    {4'd3, 3'd3}, {4'd2, 3'd1}, {4'd2, 3'd4}, {4'd0, 3'd0}
  };
  typedef enum logic [1:0] {IDLE, PLAY, PAUSED, DONE} state_t;
  state_t          r_state, w_nstate;
  logic [AW-1:0]   r_addr, w_naddr;
  logic [2:0]      r_cnt, w_ncnt;
  logic [6:0]      w_rom0, w_rom_inc, w_rom_n;
  logic [3:0]      w_note;
  logic            w_gap;
  // Entries beyond the song length read as the end marker (dur = 0)
  function automatic logic [6:0] rom(input int a);
    return (a >= 0 && a < SONG_LEN && a < 16) ? SONG[a[3:0]] : 7'd0;
  endfunction
  assign w_rom0    = rom(0);
  assign w_rom_inc = rom(int'(r_addr) + 1);
  assign w_rom_n   = rom(int'(w_naddr));
  // Next state: START restarts from anywhere, PAUSE beats BEAT, BEAT counts down and advances
  always_comb begin
    w_nstate = r_state;
    w_naddr  = r_addr;
    w_ncnt   = r_cnt;
    if (START) begin
      w_nstate = PLAY;
      w_naddr  = '0;
      w_ncnt   = w_rom0[2:0];
    end else if (r_state == PLAY) begin
      if (PAUSE) w_nstate = PAUSED;
      else if (BEAT) begin
        if (r_cnt > 3'd1) w_ncnt = r_cnt - 3'd1;
        else if (w_rom_inc[2:0] != 3'd0) begin
          w_naddr = r_addr + 1'b1;
          w_ncnt  = w_rom_inc[2:0];
        end else if (LOOP != 0) begin
          w_naddr = '0;
          w_ncnt  = w_rom0[2:0];
        end else w_nstate = DONE;
      end
    end else if (r_state == PAUSED && PAUSE) w_nstate = PLAY;
  end
`ifdef SONG_PLAYER_GAP_EN
  assign w_gap = (w_ncnt == 3'd1) && (w_rom_n[2:0] >= 3'd2);
`else
  assign w_gap = 1'b0;
`endif
  assign w_note = (w_nstate == PLAY && !w_gap && w_rom_n[6:3] >= 4'd1 && w_rom_n[6:3] <= 4'd8) ? w_rom_n[6:3] : 4'd0;
  // State, position and registered outputs all derive from the next-state values
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      note    <= '0;
      Led     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_addr  <= w_naddr;
      r_cnt   <= w_ncnt;
      note    <= w_note;
      Led     <= (w_note != 4'd0) ? (8'h80 >> (w_note - 4'd1)) : 8'h00;
      busy    <= (w_nstate == PLAY) || (w_nstate == PAUSED);
      done    <= (w_nstate == DONE);
    end
  end
endmodule

// File: tb/tb_song_player.sv
// tb_song_player: checks a stop-at-end and a looping song_player against a tick-position song model
module tb_song_player;
  logic       CLK = 1'b0;
  logic       RESET, BEAT, START, PAUSE;
  logic [3:0] n0, n1;
  logic [7:0] l0, l1;
  logic       b0, b1, d0, d1;
  int total = 0;
  int bad = 0;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_DONE = 3;
  localparam int NOTES [15] = '{3, 3, 4, 5, 5, 4, 3, 2, 1, 1, 2, 3, 3, 2, 2};
  localparam int DURS  [15] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 1, 4};
  int mode [2];
  int pos  [2];
  int song_ticks;

  song_player #(.SONG_LEN(16), .LOOP(0)) u0 (
    .CLK(CLK), .RESET(RESET), .BEAT(BEAT), .START(START), .PAUSE(PAUSE),
    .note(n0), .Led(l0), .busy(b0), .done(d0));
  song_player #(.SONG_LEN(16), .LOOP(1)) u1 (
    .CLK(CLK), .RESET(RESET), .BEAT(BEAT), .START(START), .PAUSE(PAUSE),
    .note(n1), .Led(l1), .busy(b1), .done(d1));

  always #5 CLK = ~CLK;

  function automatic int exp_note(int k);
    int acc = 0;
    if (mode[k] != M_PLAY) return 0;
    for (int e = 0; e < 15; e++) begin
      acc += DURS[e];
      if (pos[k] < acc) begin
`ifdef SONG_PLAYER_GAP_EN
        if (DURS[e] >= 2 && acc - pos[k] == 1) return 0;
`endif
        return NOTES[e];
      end
    end
    return 0;
  endfunction

  function automatic int exp_led(int n);
    return (n >= 1 && n <= 8) ? (1 << (8 - n)) : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("note0", 32'(n0), exp_note(0));
    chk("led0",  32'(l0), exp_led(exp_note(0)));
    chk("busy0", 32'(b0), int'(mode[0] == M_PLAY || mode[0] == M_PAUSE));
    chk("done0", 32'(d0), int'(mode[0] == M_DONE));
    chk("note1", 32'(n1), exp_note(1));
    chk("led1",  32'(l1), exp_led(exp_note(1)));
    chk("busy1", 32'(b1), int'(mode[1] == M_PLAY || mode[1] == M_PAUSE));
    chk("done1", 32'(d1), int'(mode[1] == M_DONE));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mode[k] = M_IDLE;
      pos[k]  = 0;
    end
  endtask

  task automatic step(input logic s, input logic p, input logic b);
    START = s;
    PAUSE = p;
    BEAT  = b;
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      if (s) begin
        mode[k] = M_PLAY;
        pos[k]  = 0;
      end else if (mode[k] == M_PLAY) begin
        if (p) mode[k] = M_PAUSE;
        else if (b) begin
          pos[k]++;
          if (pos[k] == song_ticks) begin
            if (k == 1) pos[k] = 0;
            else mode[k] = M_DONE;
          end
        end
      end else if (mode[k] == M_PAUSE && p) mode[k] = M_PLAY;
    end
    #1;
    START = 1'b0;
    PAUSE = 1'b0;
    BEAT  = 1'b0;
    check_all();
  endtask

  initial begin
    song_ticks = 0;
    for (int e = 0; e < 15; e++) song_ticks += DURS[e];
    model_reset();
    RESET = 1'b1;
    START = 1'b0;
    PAUSE = 1'b0;
    BEAT  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    RESET = 1'b0;
    step(0, 1, 1);
    step(0, 0, 1);
    step(1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1);
      if (i % 3 == 0) step(0, 0, 0);
    end
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (25) step(0, 0, 1);
    step(0, 1, 0);
    repeat (5) step(0, 0, 1);
    step(0, 1, 0);
    repeat (3) step(0, 0, 1);
    step(0, 1, 1);
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    step(0, 0, 1);
    repeat (600) step($urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    step(1, 0, 0);
    step(0, 0, 1);
    #2;
    RESET = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    check_all();
    step(1, 0, 0);
    step(0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
